// File: rtl/data_mem_responder_if.sv
// MEM-stage <-> data-memory responder bus: request/store fields from the
// pipeline, load data, stall, ack and misalign flag back from the responder.
interface data_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             ReqM;
  logic             MemWriteM;
  logic [2:0]       Funct3M;
  logic [WIDTH-1:0] AddrM;
  logic [WIDTH-1:0] WDataM;
  logic [WIDTH-1:0] RD;
  logic             StallM;
  logic             AckM;
  logic             MisalignM;

  modport master (
    output ReqM, MemWriteM, Funct3M, AddrM, WDataM,
    input  RD, StallM, AckM, MisalignM
  );

  modport slave (
    input  ReqM, MemWriteM, Funct3M, AddrM, WDataM,
    output RD, StallM, AckM, MisalignM
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data-memory responder for the MEM stage (IDLE/BUSY/DONE).
// Optional MISALIGN_TRAP_EN: flag misaligned accesses instead of force-aligning.
module data_mem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                CLK,
  input  logic                RST,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       count, count_nx;
  logic             accept, enter_done;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [AW+1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    idx;
  logic [1:0]       off;
  logic [WIDTH-1:0] rword, load_val, wsh;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [NB-1:0]    be;
  logic             misaligned;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.AddrM[WIDTH-1:AW+2];
  assign accept = (state == IDLE) && bus.ReqM;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // BUSY lasts LATENCY-1 cycles (count LATENCY-1 down to 1), so with the
  // accepting IDLE cycle the stall is exactly LATENCY cycles; count hits 0
  // as DONE is entered, and LATENCY=1 goes straight from IDLE to DONE.
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      IDLE: if (bus.ReqM) begin
        count_nx = 4'(LATENCY - 1);
        state_nx = (LATENCY == 1) ? DONE : BUSY;
      end
      BUSY: begin
        count_nx = count - 4'd1;
        if (count == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_done = (state != DONE) && (state_nx == DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.MemWriteM;
      f3_q    <= bus.Funct3M;
      addr_q  <= bus.AddrM[AW+1:0];
      wdata_q <= bus.WDataM;
    end
  end

  assign idx = addr_q[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign off        = addr_q[1:0];
`else
  assign misaligned = 1'b0;
  always_comb begin
    off = addr_q[1:0];
    case (f3_q[1:0])
      2'b01:   off = {addr_q[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = addr_q[1:0];
    endcase
  end
`endif

  assign rword = mem[idx];
  assign rbyte = rword[{off, 3'b000} +: 8];
  assign rhalf = rword[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{(WIDTH-8){rbyte[7]}}, rbyte};
      3'b001:  load_val = {{(WIDTH-16){rhalf[15]}}, rhalf};
      3'b010:  load_val = rword;
      3'b100:  load_val = {{(WIDTH-8){1'b0}}, rbyte};
      3'b101:  load_val = {{(WIDTH-16){1'b0}}, rhalf};
      default: load_val = '0;
    endcase
    if (misaligned) load_val = '0;
  end

  // Store data is replicated across lanes; the byte-enable picks the lane(s).
  always_comb begin
    be  = '0;
    wsh = wdata_q;
    case (f3_q)
      3'b000: begin
        be  = NB'(1) << off;
        wsh = {NB{wdata_q[7:0]}};
      end
      3'b001: begin
        be  = NB'(3) << {off[1], 1'b0};
        wsh = {(NB/2){wdata_q[15:0]}};
      end
      3'b010: begin
        be  = '1;
        wsh = wdata_q;
      end
      default: be = '0;
    endcase
    if (misaligned) be = '0;
  end

  always_ff @(posedge CLK) begin
    if (enter_done && we_q) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wsh[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     rd_q <= '0;
    else if (enter_done && !we_q) rd_q <= load_val;
  end

  assign bus.RD        = rd_q;
  assign bus.AckM      = (state == DONE);
  assign bus.StallM    = accept || (state == BUSY);
  assign bus.MisalignM = (state == DONE) && misaligned;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with an expected-RD scoreboard queue.
// Define MISALIGN_TRAP_EN for both bench and RTL to check the trap build.
module tb_data_mem_responder;
  localparam int W   = 32;
  localparam int D   = 256;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] model_rd = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_mis_q[$];

  data_mem_responder_if #(.WIDTH(W)) bus ();

  data_mem_responder #(.WIDTH(W), .DEPTH(D), .LATENCY(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd"},   bus.RD, model_rd);
    check({tag, "_stall"}, W'(bus.StallM), '0);
    check({tag, "_ack"},  W'(bus.AckM), '0);
    check({tag, "_mis"},  W'(bus.MisalignM), '0);
  endtask

  // Drives one request, holds ReqM through the DONE cycle, and checks stall
  // length, ack, RD and MisalignM against the scoreboard entry.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [W-1:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] exp_rd, input logic exp_mis);
    int stalls = 0;
    bit got = 0;
    logic [W-1:0] e;
    if (!we) model_rd = exp_rd;
    exp_q.push_back(model_rd);
    exp_mis_q.push_back(W'(exp_mis));
    @(negedge CLK);
    bus.ReqM = 1'b1; bus.MemWriteM = we; bus.Funct3M = f3;
    bus.AddrM = a; bus.WDataM = wd;
    for (int c = 0; c < 20 && !got; c++) begin
      #2;
      if (bus.AckM) begin
        got = 1;
        e = exp_q.pop_front();
        check({tag, "_rd"}, bus.RD, e);
        e = exp_mis_q.pop_front();
        check({tag, "_mis"}, W'(bus.MisalignM), e);
        check({tag, "_done_stall"}, W'(bus.StallM), '0);
      end else begin
        if (bus.StallM) stalls++;
        @(negedge CLK);
        if (stalls == 1) begin
          // inputs change after acceptance; the latched copy must be used
          bus.AddrM = $urandom; bus.WDataM = $urandom;
          bus.Funct3M = 3'($urandom_range(0, 7)); bus.MemWriteM = ~we;
        end
      end
    end
    if (!got) begin
      check({tag, "_ack_timeout"}, '0, 32'd1);
      void'(exp_q.pop_front());
      void'(exp_mis_q.pop_front());
    end
    check({tag, "_stall_len"}, W'(stalls), W'(LAT));
    @(negedge CLK);
    bus.ReqM = 1'b0;
    #2;
    check({tag, "_no_reack"}, W'(bus.AckM), '0);
  endtask

  initial begin
    bus.ReqM = 1'b0; bus.MemWriteM = 1'b0; bus.Funct3M = '0;
    bus.AddrM = '0; bus.WDataM = '0;

    #1 RST = 1'b0;
    #2 check_idle_outputs("reset");
    @(negedge CLK);
    @(negedge CLK) RST = 1'b1;
    repeat (3) @(negedge CLK);
    #2 check_idle_outputs("idle");

    access("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, '0, 1'b0);
    access("lw10",  1'b0, 3'b010, 32'h10, '0, 32'hDEADBEEF, 1'b0);
    access("sb13",  1'b1, 3'b000, 32'h13, 32'h00000080, '0, 1'b0);
    access("lb13",  1'b0, 3'b000, 32'h13, '0, 32'hFFFFFF80, 1'b0);
    access("lbu13", 1'b0, 3'b100, 32'h13, '0, 32'h00000080, 1'b0);
    access("lw10b", 1'b0, 3'b010, 32'h10, '0, 32'h80ADBEEF, 1'b0);
    access("lb12",  1'b0, 3'b000, 32'h12, '0, 32'hFFFFFFAD, 1'b0);

    access("sw20",  1'b1, 3'b010, 32'h20, 32'h0, '0, 1'b0);
    access("sh22",  1'b1, 3'b001, 32'h22, 32'hFFFF1234, '0, 1'b0);
    access("lhu22", 1'b0, 3'b101, 32'h22, '0, 32'h00001234, 1'b0);
    access("lh22",  1'b0, 3'b001, 32'h22, '0, 32'h00001234, 1'b0);
    access("lwwrap", 1'b0, 3'b010, 32'h20 + D*4, '0, 32'h12340000, 1'b0);

    access("ld_f3bad", 1'b0, 3'b011, 32'h10, '0, 32'h0, 1'b0);
    access("st_f3bad", 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, '0, 1'b0);
    access("lw10c",    1'b0, 3'b010, 32'h10, '0, 32'h80ADBEEF, 1'b0);

    // store aborted by reset while BUSY must never commit
    access("sw30",  1'b1, 3'b010, 32'h30, 32'hA5A5A5A5, '0, 1'b0);
    @(negedge CLK);
    bus.ReqM = 1'b1; bus.MemWriteM = 1'b1; bus.Funct3M = 3'b010;
    bus.AddrM = 32'h30; bus.WDataM = 32'h55;
    @(negedge CLK);
    #1;
    check("abort_busy_stall", W'(bus.StallM), 32'd1);
    RST = 1'b0; bus.ReqM = 1'b0;
    model_rd = '0;
    #1 check_idle_outputs("abort_rst");
    @(negedge CLK);
    #2 check("abort_noack", W'(bus.AckM), '0);
    RST = 1'b1;
    access("lw30",  1'b0, 3'b010, 32'h30, '0, 32'hA5A5A5A5, 1'b0);

    access("sw40",  1'b1, 3'b010, 32'h40, 32'hCAFEF00D, '0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    access("lw41",  1'b0, 3'b010, 32'h41, '0, 32'h0, 1'b1);
    access("sh41",  1'b1, 3'b001, 32'h41, 32'hBBBB, '0, 1'b1);
    access("lw40",  1'b0, 3'b010, 32'h40, '0, 32'hCAFEF00D, 1'b0);
    access("lh43",  1'b0, 3'b001, 32'h43, '0, 32'h0, 1'b1);
`else
    access("lw41",  1'b0, 3'b010, 32'h41, '0, 32'hCAFEF00D, 1'b0);
    access("sh41",  1'b1, 3'b001, 32'h41, 32'hBBBB, '0, 1'b0);
    access("lw40",  1'b0, 3'b010, 32'h40, '0, 32'hCAFEBBBB, 1'b0);
    access("lh43",  1'b0, 3'b001, 32'h43, '0, 32'hFFFFCAFE, 1'b0);
`endif

    check("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
